// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising receive-side checker for the Galois LFSR pattern generator.
// Build option LFSR_CHECKER_BIT_ERR_EN: error_count totals bit errors instead of word errors.
`default_nettype none

module lfsr_checker #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS      = 8'b11101,
  parameter bit              INVERT     = 1'b0,
  parameter int              LOCK_COUNT = 4,
  parameter int              LOSS_COUNT = 4,
  parameter int              CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 clr_count,
  output logic                 locked,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] error_count
);

  localparam int MC_W  = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int ML_W  = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT) : 1;
  localparam int INC_W = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_WIDTH > INC_W) ? CNT_WIDTH : INC_W) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
    lfsr_next = {x[WIDTH-2:0], 1'b0} ^ ((x[WIDTH-1] ^ INVERT) ? TAPS : '0);
  endfunction

  state_t            state;
  logic [WIDTH-1:0]  expected;
  logic [MC_W-1:0]   match_cnt;
  logic [ML_W-1:0]   miss_cnt;

  logic [WIDTH-1:0]     data_next;
  logic [WIDTH-1:0]     exp_next;
  logic [WIDTH-1:0]     diff;
  logic                 match;
  logic                 lockup;
  logic                 count_err;
  logic [INC_W-1:0]     inc;
  logic [SUM_W-1:0]     sum;
  logic [CNT_WIDTH-1:0] count_sat;

  always_comb begin
    data_next = lfsr_next(in_data);
    exp_next  = lfsr_next(expected);
    diff      = in_data ^ expected;
    match     = (diff == '0);
    lockup    = (data_next == in_data);
    count_err = in_valid && (state == LOCKED) && !match;
`ifdef LFSR_CHECKER_BIT_ERR_EN
    inc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      inc = inc + INC_W'(diff[i]);
    end
`else
    inc = INC_W'(1);
`endif
    // Wide sum so a multi-bit increment clamps in the same cycle instead of wrapping
    sum       = SUM_W'(error_count) + SUM_W'(inc);
    count_sat = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEARCH;
      locked      <= 1'b0;
      error       <= 1'b0;
      error_count <= '0;
      expected    <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
    end else begin
      error <= count_err;

      if (clr_count) begin
        error_count <= '0;
      end else if (count_err) begin
        error_count <= count_sat;
      end

      if (in_valid) begin
        case (state)
          SEARCH: begin
            // A word that maps onto itself cannot seed a running sequence
            if (!lockup) begin
              expected  <= data_next;
              match_cnt <= '0;
              state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (match) begin
              expected <= exp_next;
              if (match_cnt == MC_W'(LOCK_COUNT - 1)) begin
                match_cnt <= '0;
                state     <= LOCKED;
                locked    <= 1'b1;
              end else begin
                match_cnt <= match_cnt + MC_W'(1);
              end
            end else begin
              expected  <= data_next;
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Flywheel: never reseed from received data once locked
            expected <= exp_next;
            if (match) begin
              miss_cnt <= '0;
            end else if (miss_cnt == ML_W'(LOSS_COUNT - 1)) begin
              miss_cnt <= '0;
              state    <= SEARCH;
              locked   <= 1'b0;
            end else begin
              miss_cnt <= miss_cnt + ML_W'(1);
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed-vector bench for lfsr_checker (default instance plus a
// small-counter / long-loss instance for saturation).
`default_nettype none

module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        clr_count;

  logic        locked;
  logic        error;
  logic [15:0] error_count;
  logic        locked_s;
  logic        error_s;
  logic [3:0]  error_count_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .clr_count   (clr_count),
    .locked      (locked),
    .error       (error),
    .error_count (error_count)
  );

  lfsr_checker #(
    .CNT_WIDTH  (4),
    .LOSS_COUNT (32)
  ) dut_sat (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .clr_count   (clr_count),
    .locked      (locked_s),
    .error       (error_s),
    .error_count (error_count_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic clr);
    in_valid  = v;
    in_data   = d;
    clr_count = clr;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    clr_count = 1'b0;
  endtask

  task automatic feed_lock_words();
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h04, 1'b0);
    step(1'b1, 8'h08, 1'b0);
    check("no_lock_at_08", {31'd0, locked}, 32'd0);
    step(1'b1, 8'h10, 1'b0);
  endtask

  // Loss scenario: expected words 87,13,26,4C replaced by 00
`ifdef LFSR_CHECKER_BIT_ERR_EN
  localparam int LOSS_TOTAL = 1 + 4 + 3 + 3 + 3;
`else
  localparam int LOSS_TOTAL = 1 + 4;
`endif

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    clr_count = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    reset = 1'b0;
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_error",  {31'd0, error},  32'd0);
    check("rst_count",  {16'd0, error_count}, 32'd0);

    // Lock on 01,02,04,08,10
    feed_lock_words();
    check("lock_after_10", {31'd0, locked}, 32'd1);
    check("lock_count",    {16'd0, error_count}, 32'd0);

    // Single corrupted word, flywheel carries on
    step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h1D, 1'b0);
    step(1'b1, 8'h3A, 1'b0);
    check("no_err_before_bad", {31'd0, error}, 32'd0);
    step(1'b1, 8'h75, 1'b0);
    check("err_pulse",     {31'd0, error}, 32'd1);
    check("err_count_1",   {16'd0, error_count}, 32'd1);
    step(1'b1, 8'hE8, 1'b0);
    check("flywheel_noerr", {31'd0, error}, 32'd0);
    check("flywheel_count", {16'd0, error_count}, 32'd1);
    check("flywheel_lock",  {31'd0, locked}, 32'd1);
    step(1'b1, 8'hCD, 1'b0);
    check("cd_noerr", {31'd0, error}, 32'd0);

    // Loss of lock after four consecutive misses
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'h00, 1'b0);
      check("loss_err", {31'd0, error}, 32'd1);
      check("loss_locked", {31'd0, locked}, (i < 3) ? 32'd1 : 32'd0);
    end
    check("loss_count", {16'd0, error_count}, LOSS_TOTAL);
    feed_lock_words();
    check("relock", {31'd0, locked}, 32'd1);
    check("relock_count", {16'd0, error_count}, LOSS_TOTAL);

    // Reset mid-lock, with a valid word presented during reset
    reset = 1'b1;
    step(1'b1, 8'h55, 1'b0);
    reset = 1'b0;
    check("midrst_locked", {31'd0, locked}, 32'd0);
    check("midrst_error",  {31'd0, error},  32'd0);
    check("midrst_count",  {16'd0, error_count}, 32'd0);
    check("midrst_count_s", {28'd0, error_count_s}, 32'd0);

    // Lock-up word never seeds
    for (int i = 0; i < 50; i++) step(1'b1, 8'h00, 1'b0);
    check("lockup_locked", {31'd0, locked}, 32'd0);
    check("lockup_count",  {16'd0, error_count}, 32'd0);
    check("lockup_error",  {31'd0, error}, 32'd0);

    // Gapped stream: idle cycles carry garbage data that must be ignored
    step(1'b1, 8'h01, 1'b0); step(1'b0, 8'hFF, 1'b0);
    step(1'b1, 8'h02, 1'b0); step(1'b0, 8'hFF, 1'b0);
    step(1'b1, 8'h04, 1'b0); step(1'b0, 8'hFF, 1'b0);
    step(1'b1, 8'h08, 1'b0); step(1'b0, 8'hFF, 1'b0);
    check("gap_no_early_lock", {31'd0, locked}, 32'd0);
    step(1'b1, 8'h10, 1'b0);
    check("gap_lock", {31'd0, locked}, 32'd1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h20, 1'b0);
    check("gap_match", {31'd0, error}, 32'd0);
    step(1'b1, 8'h41, 1'b0);
    check("gap_bad_err",   {31'd0, error}, 32'd1);
    check("gap_bad_count", {16'd0, error_count}, 32'd1);
    step(1'b1, 8'h00, 1'b1);
    check("clr_err",   {31'd0, error}, 32'd1);
    check("clr_count", {16'd0, error_count}, 32'd0);
    step(1'b1, 8'h1D, 1'b0);
    check("post_clr_noerr",  {31'd0, error}, 32'd0);
    check("post_clr_locked", {31'd0, locked}, 32'd1);
    step(1'b0, 8'h00, 1'b0);
    check("idle_err_clear", {31'd0, error}, 32'd0);

    // Saturation on the 4-bit counter instance
    check("sat_start", {28'd0, error_count_s}, 32'd0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'h00, 1'b0);
    check("sat_count",  {28'd0, error_count_s}, 32'd15);
    check("sat_locked", {31'd0, locked_s}, 32'd1);
    check("sat_dut_lost", {31'd0, locked}, 32'd0);
    step(1'b1, 8'h00, 1'b1);
    check("sat_clr_err",   {31'd0, error_s}, 32'd1);
    check("sat_clr_count", {28'd0, error_count_s}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
